// File: rtl/reg_file_pkg.sv
// Shared constants and handshake controller state encodings for the register file.
package reg_file_pkg;

   localparam int REG_NUM   = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      CTL_IDLE = 2'd0,
      CTL_ACK  = 2'd1,
      CTL_DROP = 2'd2
   } ctl_state_t;

   // Both ports share the generic controller, so their encodings alias it.
   localparam ctl_state_t R_IDLE = CTL_IDLE;
   localparam ctl_state_t R_ACK  = CTL_ACK;
   localparam ctl_state_t R_DROP = CTL_DROP;
   localparam ctl_state_t W_IDLE = CTL_IDLE;
   localparam ctl_state_t W_ACK  = CTL_ACK;
   localparam ctl_state_t W_DROP = CTL_DROP;

endpackage

// File: rtl/req_ack_ctl.sv
// Request -> one-cycle ack -> wait-for-drop controller; fire marks the sampling edge.
module req_ack_ctl
   import reg_file_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   output logic       fire,
   output logic       ack,
   output ctl_state_t state
);

   assign fire = (state == CTL_IDLE) && req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CTL_IDLE;
         ack   <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            CTL_IDLE: if (req) begin
               state <= CTL_ACK;
               ack   <= 1'b1;
            end
            CTL_ACK:  state <= req ? CTL_DROP : CTL_IDLE;
            CTL_DROP: if (!req) state <= CTL_IDLE;
            default:  state <= CTL_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/reg_file.sv
// 32-entry integer register file, x0 hardwired to zero, with independent
// read and write request/ack ports and a same-edge write-to-read bypass.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int REG_SZ = 32,
   parameter int IDX_W  = REG_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_re,
   input  logic [IDX_W-1:0]  reg_idx,
   output logic              reg_rack,
   output logic [REG_SZ-1:0] reg_in,
   input  logic              wb_we,
   input  logic [IDX_W-1:0]  wb_idx,
   input  logic [REG_SZ-1:0] wb_val,
   output logic              wb_wack,
   output logic              busy
);

   logic [REG_SZ-1:0] regs [REG_NUM];
   logic              rd_fire, wr_fire;
   ctl_state_t        rd_state, wr_state;
   logic              wr_live;

   req_ack_ctl u_rd_ctl (
      .clk   (clk),
      .rst   (rst),
      .req   (reg_re),
      .fire  (rd_fire),
      .ack   (reg_rack),
      .state (rd_state)
   );

   req_ack_ctl u_wr_ctl (
      .clk   (clk),
      .rst   (rst),
      .req   (wb_we),
      .fire  (wr_fire),
      .ack   (wb_wack),
      .state (wr_state)
   );

   assign busy    = (rd_state != R_IDLE) || (wr_state != W_IDLE);
   // A write that actually lands in storage this edge (x0 writes are dropped).
   assign wr_live = wr_fire && (wb_idx != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wb_idx] <= wb_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_in <= '0;
      end else if (rd_fire) begin
         if (reg_idx == '0)
            reg_in <= '0;
         else if (wr_live && (wb_idx == reg_idx))
            reg_in <= wb_val;
         else
            reg_in <= regs[reg_idx];
      end
   end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the RISC-V pipeline: 32 × `REG_SZ` registers with x0 hardwired to zero. It is the responder for the decode stage's register-read request/acknowledge handshake (`reg_re`/`reg_idx` → `reg_rack`/`reg_in`). It also services the write-back stage's write handshake. Each port is an independent request/ack channel with a registered one-cycle response and return-to-idle, and a write-to-read bypass.

## Interface
- `REG_SZ`, 32, register width in bits
- `IDX_W`, 5, register index width (32 entries)

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `reg_re`  in  1  read request from decode; held until `reg_rack` seen
- `reg_idx`  in  `IDX_W`  read index; stable while `reg_re` high
- `reg_rack`  out  1  read acknowledge, one-cycle pulse
- `reg_in`  out  `REG_SZ`  read data; valid from `reg_rack` until next ack
- `wb_we`  in  1  write request from write-back; held until `wb_wack`
- `wb_idx`  in  `IDX_W`  write index
- `wb_val`  in  `REG_SZ`  write data
- `wb_wack`  out  1  write acknowledge, one-cycle pulse
- `busy`  out  1  high whenever either port is outside its idle state

## Operation
- Read FSM states: R_IDLE, R_ACK, R_DROP.
  - R_IDLE: `reg_re` sampled high → latch `reg_in` and go to R_ACK.
    - Data source: 0 if `reg_idx`==0; otherwise `wb_val` on a same-edge write to the same nonzero index (bypass); otherwise `regs[reg_idx]`.
  - R_ACK: `reg_rack`=1 for this cycle only. Go to R_DROP if `reg_re` is still high, else go to R_IDLE.
  - R_DROP: wait for `reg_re` sampled low, then go to R_IDLE. A request that stays high never produces a second ack.
- Write FSM states: W_IDLE, W_ACK, W_DROP, with the same shape as the read FSM.
  - W_IDLE: `wb_we` sampled high → write `regs[wb_idx]`=`wb_val` on that edge, unless `wb_idx`==0. Writes to x0 are discarded but still acknowledged.
  - W_ACK: `wb_wack` pulses for one cycle.
  - W_DROP: wait for `wb_we` low.
- `reg_in` keeps its last value outside R_ACK. It is not cleared after the ack.
- The read and write ports are fully concurrent. Neither port stalls the other.
- `busy` = (read state ≠ R_IDLE) | (write state ≠ W_IDLE).

## Timing
- Reset: all 32 registers = 0; both FSMs go to idle; `reg_rack`=0, `wb_wack`=0, `reg_in`=0, `busy`=0. Reset mid-handshake aborts the handshake with no ack. A requester that is still high after reset is served afresh.
- Read latency: request sampled at edge k → `reg_rack`/`reg_in` valid after edge k, for exactly one cycle. Minimum request-to-request spacing is 3 cycles (ack, drop, idle).
- Write latency: the register is updated at sampling edge k. `wb_wack` is high after edge k. A read sampled at edge k+1 or later sees the new value.
- Same-edge read and write, same nonzero index: the read returns `wb_val` (new value).
- Same-edge read and write, different index: the read returns the stored old value of its own index.
- Back-to-back writes to the same index: the last write wins. Each write is acked separately.
- Index width arithmetic: no wrap-around; all 32 indices are valid.

## Structure
- Shared package (`riscv_const.v` style include): `REG_NUM`=32, `REG_IDX_W`=5, and the read/write FSM state encodings (2 bits each).
- Sub-module `req_ack_ctl`: the generic 3-state request → one-cycle-ack → wait-drop controller. It is instantiated twice (read, write). The storage array and bypass mux live in the top.

## Test plan
- Reset, then read x5 → `reg_rack` pulse 1 cycle after request, `reg_in`=0, `busy` back to 0 after `reg_re` drops.
- Write x5=0xDEADBEEF, then read x5 → `wb_wack` 1 pulse; read returns 0xDEADBEEF.
- Write x0=0x1234, then read x0 → write acked; read returns 0.
- Read x7 and write x7=0x55 sampled on the same edge → `reg_in`=0x55.
- Read x8 on the same edge as a write of x7 → `reg_in` = old x8 value.
- Hold `reg_re` high for 10 cycles → exactly one `reg_rack`. Assert `rst` while in R_ACK/R_DROP with `reg_re` still high → outputs 0 and all registers 0 (the stored value of x5 is discarded). One cycle after `rst` drops, the still-high request is sampled afresh: a single `reg_rack` pulse with `reg_in`=0.
